serial_subtractor_4bit: RTL and testbench
=========================================

Name: serial_subtractor_4bit

Overview:
Bit-serial ripple-borrow subtractor. It computes Diff = A - B - Bin one bit per clock, LSB first, through a single full-subtractor cell and a registered borrow. It is the subtract-direction, time-multiplexed counterpart to the combinational ripple-carry adder in the arithmetic library. It is used where area matters more than latency, behind a start/done handshake.

Parameters:
WIDTH, 4, operand and result width in bits (at least 2); the 4-bit name reflects the default.

Ports:
clk      input   1      single clock, rising edge
rst_n    input   1      asynchronous active-low reset
start    input   1      request; sampled only when idle (busy=0)
A        input   WIDTH  minuend, captured on an accepted start
B        input   WIDTH  subtrahend, captured on an accepted start
Bin      input   1      borrow-in, captured on an accepted start
busy     output  1      high while an operation is in progress
done     output  1      one-cycle pulse when Diff/Bout update
Diff     output  WIDTH  result register A - B - Bin (mod 2^WIDTH)
Bout     output  1      final borrow-out; 1 when A < B + Bin (unsigned)

Behaviour:
- Reset (rst_n=0, asynchronous): FSM goes to IDLE; busy=0, done=0, Diff=0, Bout=0; the shift registers, bit counter and borrow register clear. Reset mid-operation aborts it and produces no done pulse.
- FSM states: IDLE and RUN.
- IDLE, start=1 at an edge: latch A into sa, B into sb, Bin into br; clear the bit counter; go to RUN; busy=1 from the next cycle.
- IDLE, start=0: remain in IDLE.
- RUN, each edge processes the LSB of sa/sb:
  - d = a ^ b ^ br
  - br_next = (~a & b) | (~a & br) | (b & br)
  - d shifts into the MSB of the result shift register
  - sa/sb shift right
  - the counter increments
- RUN, on the edge that processes bit WIDTH-1:
  - copy the result shift register (including that final bit) into Diff, and br_next into Bout
  - pulse done=1 for exactly the following cycle
  - return to IDLE; busy=0 in that same cycle
- Latency: if start is accepted at edge k, Diff/Bout/done are visible after edge k+WIDTH. Done is high for the single cycle between edges k+WIDTH and k+WIDTH+1. Throughput is one operation per WIDTH+1 cycles.
- start while busy=1: ignored; no effect on operands or timing.
- start asserted during the done cycle: accepted, because the state is IDLE. The new operation begins; Diff/Bout keep the old result until the new completion.
- Diff/Bout hold their value between completions. They never show partial results.
- A, B and Bin may change freely after acceptance; only the latched copies are used.
- Wrap-around: Diff is the modulo-2^WIDTH result. Example: 0 - 1 gives all-ones with Bout=1.
- Bout is the unsigned borrow. Signed interpretation is left to the consumer unless the optional feature is compiled in.

Optional Feature:
Macro SERIAL_SUB_OVF_EN.
- Defined: adds output Ovf (1 bit), two's-complement overflow of A - B - Bin.
  - Computed as Ovf = (a_msb ^ b_msb) & (a_msb ^ d_msb), using the latched MSBs of A and B and the final result bit.
  - Registered together with Diff; resets to 0; held until the next completion.
- Not defined: no Ovf port and no extra logic. All other behaviour is identical.

Test Plan:
- Reset, then A=9, B=3, Bin=0, start pulse -> busy for 4 cycles; done pulses 4 edges after acceptance; Diff=6, Bout=0.
- A=3, B=9, Bin=0 -> Diff=4'hA, Bout=1. Then A=0, B=0, Bin=1 -> Diff=4'hF, Bout=1 (wrap-around).
- During a run of A=15, B=5, change A/B and pulse start mid-run -> second start ignored; result Diff=10, Bout=0; no extra done pulse.
- Back-to-back: hold start=1 through the done cycle with A=7, B=7, Bin=0 -> the first result appears, the next operation starts immediately; second done gives Diff=0, Bout=0.
- Assert rst_n=0 for one cycle at bit 2 of an operation -> busy=0, done=0, Diff=0, Bout=0; no done pulse follows.
- With SERIAL_SUB_OVF_EN: A=4'h8, B=1, Bin=0 -> Diff=7, Bout=0, Ovf=1. Then A=5, B=2 -> Diff=3, Ovf=0.

Source files
------------

// File: rtl/serial_subtractor_4bit_if.sv
// Request/result bundle for the bit-serial subtractor; Ovf exists only with SERIAL_SUB_OVF_EN.
// The master drives start/operands; the slave (the subtractor) returns status and result.
interface serial_subtractor_4bit_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Diff;
    logic             Bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             Ovf;

    modport master (output start, A, B, Bin, input busy, done, Diff, Bout, Ovf);
    modport slave  (input start, A, B, Bin, output busy, done, Diff, Bout, Ovf);
`else
    modport master (output start, A, B, Bin, input busy, done, Diff, Bout);
    modport slave  (input start, A, B, Bin, output busy, done, Diff, Bout);
`endif
endinterface

// File: rtl/serial_subtractor_4bit.sv
// Bit-serial A - B - Bin, LSB first, one full-subtractor cell; optional Ovf via SERIAL_SUB_OVF_EN.
// Latency: result and done pulse appear WIDTH cycles after the start edge.
// Backpressure: start is sampled only while idle; requests during busy are dropped.
module serial_subtractor_4bit #(
    parameter int WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    serial_subtractor_4bit_if.slave io
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] diff_q;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             bout_q;
    logic             busy_q;
    logic             done_q;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_q;
`endif

    logic             a_bit;
    logic             b_bit;
    logic             d_bit;
    logic             br_next;
    logic             last_bit;
    logic [WIDTH-1:0] res_next;

    assign a_bit    = sa[0];
    assign b_bit    = sb[0];
    assign d_bit    = a_bit ^ b_bit ^ br;
    assign br_next  = (~a_bit & b_bit) | (~a_bit & br) | (b_bit & br);
    assign last_bit = (cnt == CW'(WIDTH - 1));
    // Result bits enter at the MSB so the first (LSB) bit lands at bit 0 after WIDTH shifts.
    assign res_next = {d_bit, res[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sa     <= '0;
            sb     <= '0;
            res    <= '0;
            diff_q <= '0;
            cnt    <= '0;
            br     <= 1'b0;
            bout_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (io.start) begin
                        sa     <= io.A;
                        sb     <= io.B;
                        br     <= io.Bin;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    br  <= br_next;
                    res <= res_next;
                    cnt <= cnt + CW'(1);
                    if (last_bit) begin
                        diff_q <= res_next;
                        bout_q <= br_next;
`ifdef SERIAL_SUB_OVF_EN
                        // By the last bit the operand MSBs have shifted down to bit 0.
                        ovf_q  <= (a_bit ^ b_bit) & (a_bit ^ d_bit);
`endif
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign io.busy = busy_q;
    assign io.done = done_q;
    assign io.Diff = diff_q;
    assign io.Bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign io.Ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor_4bit.sv
// Bench for serial_subtractor_4bit: vector table plus directed multi-cycle sequences,
// results checked through a scoreboard popped on every done pulse.
module tb_serial_subtractor_4bit;
    localparam int W = 4;

    logic clk;
    logic rst_n;

    serial_subtractor_4bit_if #(.WIDTH(W)) ifc ();

    serial_subtractor_4bit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } vec_t;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && ifc.done) begin
            done_cnt++;
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done with empty scoreboard at %0t", $time);
            end else begin
                mon_e = sbq.pop_front();
                chk("sb_diff", 32'(ifc.Diff), 32'(mon_e.d));
                chk("sb_bout", 32'(ifc.Bout), 32'(mon_e.bo));
`ifdef SERIAL_SUB_OVF_EN
                chk("sb_ovf", 32'(ifc.Ovf), 32'(mon_e.ov));
`endif
            end
        end
    end

    function automatic exp_t mk(input logic [W-1:0] d, input logic bo, input logic ov);
        exp_t e;
        e.d  = d;
        e.bo = bo;
        e.ov = ov;
        return e;
    endfunction

    // Caller is at posedge+1 with the DUT idle; returns at posedge+1, idle again.
    task automatic run_op(input vec_t v);
        int base;
        base      = done_cnt;
        ifc.A     = v.a;
        ifc.B     = v.b;
        ifc.Bin   = v.bin;
        ifc.start = 1'b1;
        sbq.push_back(mk(v.d, v.bo, v.ov));
        @(posedge clk); #1;
        ifc.start = 1'b0;
        ifc.A     = ~v.a;
        ifc.B     = ~v.b;
        for (int i = 1; i < W; i++) begin
            @(posedge clk); #1;
            chk("busy_run", 32'(ifc.busy), 32'd1);
            chk("done_early", 32'(ifc.done), 32'd0);
        end
        @(posedge clk); #1;
        chk("done_pulse", 32'(ifc.done), 32'd1);
        chk("busy_end", 32'(ifc.busy), 32'd0);
        @(posedge clk); #1;
        chk("done_once", 32'(ifc.done), 32'd0);
        chk("done_count", 32'(done_cnt - base), 32'd1);
    endtask

    task automatic wait_done(input int target, input int limit, input string name);
        int n;
        n = 0;
        while (done_cnt < target && n < limit) begin
            @(negedge clk); #1;
            n++;
        end
        chk(name, 32'(done_cnt >= target), 32'd1);
    endtask

    vec_t tbl[13];
    int   base;

    initial begin
        // a, b, bin, diff, bout, ovf
        tbl[0]  = '{4'd9,  4'd3,  1'b0, 4'd6,  1'b0, 1'b1};
        tbl[1]  = '{4'd3,  4'd9,  1'b0, 4'hA,  1'b1, 1'b1};
        tbl[2]  = '{4'd0,  4'd0,  1'b1, 4'hF,  1'b1, 1'b0};
        tbl[3]  = '{4'h8,  4'd1,  1'b0, 4'd7,  1'b0, 1'b1};
        tbl[4]  = '{4'd5,  4'd2,  1'b0, 4'd3,  1'b0, 1'b0};
        tbl[5]  = '{4'd15, 4'd5,  1'b0, 4'd10, 1'b0, 1'b0};
        tbl[6]  = '{4'd12, 4'd4,  1'b0, 4'd8,  1'b0, 1'b0};
        tbl[7]  = '{4'd7,  4'd7,  1'b0, 4'd0,  1'b0, 1'b0};
        tbl[8]  = '{4'd0,  4'd1,  1'b0, 4'hF,  1'b1, 1'b0};
        tbl[9]  = '{4'd15, 4'd15, 1'b1, 4'hF,  1'b1, 1'b0};
        tbl[10] = '{4'd6,  4'd5,  1'b1, 4'd0,  1'b0, 1'b0};
        tbl[11] = '{4'd10, 4'd3,  1'b1, 4'd6,  1'b0, 1'b1};
        tbl[12] = '{4'd4,  4'd12, 1'b0, 4'd8,  1'b1, 1'b1};

        rst_n     = 1'b0;
        ifc.start = 1'b0;
        ifc.A     = '0;
        ifc.B     = '0;
        ifc.Bin   = 1'b0;
        #1;
        chk("rst_busy", 32'(ifc.busy), 32'd0);
        chk("rst_done", 32'(ifc.done), 32'd0);
        chk("rst_diff", 32'(ifc.Diff), 32'd0);
        chk("rst_bout", 32'(ifc.Bout), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) run_op(tbl[i]);

        // Reset while bit 2 is in flight: abort, outputs clear, no done later.
        ifc.A     = 4'd9;
        ifc.B     = 4'd2;
        ifc.Bin   = 1'b0;
        ifc.start = 1'b1;
        @(posedge clk); #1;
        ifc.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(ifc.busy), 32'd0);
        chk("abort_done", 32'(ifc.done), 32'd0);
        chk("abort_diff", 32'(ifc.Diff), 32'd0);
        chk("abort_bout", 32'(ifc.Bout), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        base  = done_cnt;
        repeat (2 * W) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(done_cnt - base), 32'd0);
        chk("abort_idle", 32'(ifc.busy), 32'd0);

        // Start pulsed mid-run with new operands must be ignored.
        base      = done_cnt;
        ifc.A     = 4'd15;
        ifc.B     = 4'd5;
        ifc.Bin   = 1'b0;
        ifc.start = 1'b1;
        sbq.push_back(mk(4'd10, 1'b0, 1'b0));
        @(posedge clk); #1;
        ifc.start = 1'b0;
        @(posedge clk); #1;
        ifc.A     = 4'd3;
        ifc.B     = 4'd9;
        ifc.start = 1'b1;
        @(posedge clk); #1;
        ifc.start = 1'b0;
        repeat (3 * W) @(posedge clk);
        #1;
        chk("midrun_one_done", 32'(done_cnt - base), 32'd1);
        chk("midrun_diff_hold", 32'(ifc.Diff), 32'd10);

        // Back-to-back: start held through the done cycle launches the next op.
        base      = done_cnt;
        ifc.A     = 4'd12;
        ifc.B     = 4'd4;
        ifc.Bin   = 1'b0;
        ifc.start = 1'b1;
        sbq.push_back(mk(4'd8, 1'b0, 1'b0));
        sbq.push_back(mk(4'd0, 1'b0, 1'b0));
        @(posedge clk); #1;
        ifc.A = 4'd7;
        ifc.B = 4'd7;
        wait_done(base + 1, 3 * W, "b2b_first_timeout");
        @(posedge clk); #1;
        ifc.start = 1'b0;
        chk("b2b_busy_again", 32'(ifc.busy), 32'd1);
        chk("b2b_diff_old", 32'(ifc.Diff), 32'd8);
        wait_done(base + 2, 3 * W, "b2b_second_timeout");
        @(posedge clk); #1;
        chk("b2b_diff_new", 32'(ifc.Diff), 32'd0);

        repeat (2) @(posedge clk);
        #1;
        chk("sb_empty", 32'(sbq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
